// File: rtl/pattern_detector_cfg.sv
// rtl/pattern_detector_cfg.sv - runtime-programmable serial pattern detector (optional PD_MASK_EN adds cfg_mask)
module pattern_detector_cfg #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
`ifdef PD_MASK_EN
  input  logic [MAX_LEN-1:0] cfg_mask,
`endif
  input  logic               d_i,
  input  logic               v_i,
  output logic               pattern_detect,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               armed
);

  typedef enum logic [1:0] {IDLE, FILL, ARMED} state_t;

  state_t             state, state_n;
  // Only the newest MAX_LEN-1 bits are kept; the incoming bit completes the window.
  logic [MAX_LEN-2:0] sr, sr_n;
  logic [LEN_W-1:0]   fill_cnt, fill_n;
  logic [MAX_LEN-1:0] pat, pat_n;
  logic [LEN_W-1:0]   len, len_n;
  logic               ovl, ovl_n;
  logic [MAX_LEN-1:0] dc_mask;
  logic               det_n, err_n;
  logic [CNT_W-1:0]   cnt_n;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               cfg_ok;
  logic               hit;

`ifdef PD_MASK_EN
  logic [MAX_LEN-1:0] mask_q;
  assign dc_mask = mask_q;

  // Don't-care mask is loaded alongside the pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
    end else if (cfg_we && cfg_ok) begin
      mask_q <= cfg_mask;
    end
  end
`else
  assign dc_mask = '0;
`endif

  assign window   = {sr, d_i};
  assign fill_inc = fill_cnt + 1'b1;
  assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign armed    = (state == ARMED);

  // Positions at or above the programmed length never take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len);
    end
    hit = (((window ^ pat) & len_mask & ~dc_mask) == '0);
  end

  // Next-state and output logic: config beats data, IDLE ignores data.
  always_comb begin
    state_n = state;
    sr_n    = sr;
    fill_n  = fill_cnt;
    pat_n   = pat;
    len_n   = len;
    ovl_n   = ovl;
    cnt_n   = match_count;
    det_n   = 1'b0;
    err_n   = 1'b0;
    if (cfg_we) begin
      if (cfg_ok) begin
        pat_n   = cfg_pattern;
        len_n   = cfg_len;
        ovl_n   = cfg_overlap;
        sr_n    = '0;
        fill_n  = '0;
        cnt_n   = '0;
        state_n = (cfg_len == LEN_W'(1)) ? ARMED : FILL;
      end else begin
        err_n = 1'b1;
      end
    end else if (v_i && (state != IDLE)) begin
      sr_n = window[MAX_LEN-2:0];
      if (state == FILL) begin
        fill_n = fill_inc;
        if (fill_inc == len) begin
          state_n = ARMED;
        end
      end
      if (((state == FILL) && (fill_inc == len) || (state == ARMED)) && hit) begin
        det_n = 1'b1;
        if (match_count != '1) begin
          cnt_n = match_count + 1'b1;
        end
        if (!ovl) begin
          sr_n    = '0;
          fill_n  = '0;
          state_n = (len == LEN_W'(1)) ? ARMED : FILL;
        end
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      sr             <= '0;
      fill_cnt       <= '0;
      pat            <= '0;
      len            <= '0;
      ovl            <= 1'b0;
      match_count    <= '0;
      pattern_detect <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      state          <= state_n;
      sr             <= sr_n;
      fill_cnt       <= fill_n;
      pat            <= pat_n;
      len            <= len_n;
      ovl            <= ovl_n;
      match_count    <= cnt_n;
      pattern_detect <= det_n;
      cfg_err        <= err_n;
    end
  end

endmodule

// File: tb/tb_pattern_detector_cfg.sv
// tb/tb_pattern_detector_cfg.sv - scoreboard bench for pattern_detector_cfg
module tb_pattern_detector_cfg;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_mask;
  logic       d_i;
  logic       v_i;
  logic       pattern_detect, pattern_detect_s;
  logic [15:0] match_count;
  logic [3:0]  match_count_s;
  logic       cfg_err, cfg_err_s;
  logic       armed, armed_s;

  always #5 clk = ~clk;

  pattern_detector_cfg #(.MAX_LEN(8), .LEN_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
`ifdef PD_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .d_i(d_i), .v_i(v_i), .pattern_detect(pattern_detect),
    .match_count(match_count), .cfg_err(cfg_err), .armed(armed)
  );

  pattern_detector_cfg #(.MAX_LEN(8), .LEN_W(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
`ifdef PD_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .d_i(d_i), .v_i(v_i), .pattern_detect(pattern_detect_s),
    .match_count(match_count_s), .cfg_err(cfg_err_s), .armed(armed_s)
  );

  typedef struct {int cyc; int cnt;} exp_t;
  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   model_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] p, input int l, input bit ov, input logic [7:0] m, input bit with_v);
    cfg_pattern = p;
    cfg_len     = 4'(l);
    cfg_overlap = ov;
    cfg_mask    = m;
    cfg_we      = 1'b1;
    v_i         = with_v;
    d_i         = 1'b0;
    if (l >= 1 && l <= 8) model_cnt = 0;
    tick;
    cfg_we = 1'b0;
    v_i    = 1'b0;
  endtask

  task automatic send(input bit b, input bit hit);
    d_i = b;
    v_i = 1'b1;
    if (hit) begin
      model_cnt++;
      sb.push_back('{cyc + 1, model_cnt});
    end
    tick;
    v_i = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      d_i = 1'($urandom);
      v_i = 1'b0;
      tick;
    end
  endtask

  // Bits and expected-hit flags are given MSB first.
  task automatic send_seq(input logic [15:0] bits, input logic [15:0] hits, input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      send(bits[n-1-i], hits[n-1-i]);
      if (maxgap > 0) gap(int'($urandom_range(1, maxgap)));
    end
  endtask

  task automatic drain(input string name);
    tick;
    check(name, sb.size(), 0);
  endtask

  // Monitor: every pulse must match the next queued expectation in time and count.
  initial begin
    forever begin
      @(negedge clk);
      if (pattern_detect) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: pattern_detect=1 at cycle %0d, expected 0", cyc);
        end else begin
          e = sb.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_count", int'(match_count), e.cnt);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_mask = '0; d_i = 1'b0; v_i = 1'b1;
    repeat (2) tick;
    check("rst_detect", int'(pattern_detect), 0);
    check("rst_count", int'(match_count), 0);
    check("rst_err", int'(cfg_err), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_sat_count", int'(match_count_s), 0);
    rst = 1'b0; v_i = 1'b0;
    // Unconfigured: data ignored.
    send_seq(16'b1111, 16'b0000, 4, 0);
    check("idle_armed", int'(armed), 0);

    // Overlapping 01101.
    load(8'b01101, 5, 1'b1, 8'h00, 1'b0);
    check("t1_fill_armed", int'(armed), 0);
    send_seq(16'b01101101, 16'b00001001, 8, 0);
    drain("t1_pending");
    check("t1_count", int'(match_count), 2);
    check("t1_armed", int'(armed), 1);

    // Non-overlapping 01101.
    load(8'b01101, 5, 1'b0, 8'h00, 1'b0);
    send_seq(16'b01101, 16'b00001, 5, 0);
    check("t2_armed_after_hit", int'(armed), 0);
    send_seq(16'b101, 16'b000, 3, 0);
    drain("t2_pending");
    check("t2_armed", int'(armed), 0);
    check("t2_count", int'(match_count), 1);

    // Overlapping with idle gaps of random data.
    load(8'b01101, 5, 1'b1, 8'h00, 1'b0);
    send_seq(16'b01101101, 16'b00001001, 8, 3);
    drain("t3_pending");
    check("t3_count", int'(match_count), 2);

    // Single-bit pattern, back-to-back pulses, then saturation of the narrow counter.
    load(8'b1, 1, 1'b1, 8'h00, 1'b0);
    check("t4_armed", int'(armed), 1);
    send_seq(16'b1101, 16'b1101, 4, 0);
    check("t4_count3", int'(match_count), 3);
    for (int i = 0; i < 20; i++) send(1'b1, 1'b1);
    drain("t4_pending");
    check("t4_count23", int'(match_count), 23);
    check("t4_sat", int'(match_count_s), 15);

    // Illegal lengths rejected, prior config and partial fill preserved.
    load(8'b01101, 5, 1'b1, 8'h00, 1'b0);
    send_seq(16'b0110, 16'b0000, 4, 0);
    load(8'hFF, 0, 1'b0, 8'h00, 1'b0);
    check("t5_err_len0", int'(cfg_err), 1);
    tick;
    check("t5_err_clear", int'(cfg_err), 0);
    load(8'hFF, 9, 1'b0, 8'h00, 1'b0);
    check("t5_err_len9", int'(cfg_err), 1);
    send(1'b1, 1'b1);
    check("t5_err_clear2", int'(cfg_err), 0);
    drain("t5_pending");
    check("t5_count", int'(match_count), 1);
    // Config coincident with valid data: the bit is dropped.
    load(8'b01101, 5, 1'b1, 8'h00, 1'b1);
    send_seq(16'b1101, 16'b0000, 4, 0);
    drain("t5_pending2");
    check("t5_cv_armed", int'(armed), 0);
    check("t5_cv_count", int'(match_count), 0);

    // Reset mid-stream overrides simultaneous config and data.
    load(8'b01101, 5, 1'b1, 8'h00, 1'b0);
    send_seq(16'b011, 16'b000, 3, 0);
    rst = 1'b1; cfg_we = 1'b1; cfg_pattern = 8'b1; cfg_len = 4'd1; cfg_overlap = 1'b1;
    v_i = 1'b1; d_i = 1'b1;
    tick;
    rst = 1'b0; cfg_we = 1'b0; v_i = 1'b0;
    check("t6_detect", int'(pattern_detect), 0);
    check("t6_count", int'(match_count), 0);
    check("t6_err", int'(cfg_err), 0);
    check("t6_armed", int'(armed), 0);
    send_seq(16'b01101, 16'b00000, 5, 0);
    drain("t6_pending");
    check("t6_idle_armed", int'(armed), 0);
    check("t6_idle_count", int'(match_count), 0);

`ifdef PD_MASK_EN
    load(8'b01101, 5, 1'b1, 8'b00100, 1'b0);
    send_seq(16'b01001, 16'b00001, 5, 0);
    drain("mask_pending");
    check("mask_count", int'(match_count), 1);
`endif

    repeat (2) tick;
    check("final_pending", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_detector_cfg.md
Name: pattern_detector_cfg

Overview:
Runtime-programmable serial bit-pattern detector, the parametrised successor to the fixed 5-bit overlapping detector. Pattern value and length (1..MAX_LEN) are loaded through a config strobe. Overlapping or non-overlapping detection is selected per load. Sits on a valid-qualified serial bit stream and emits a one-cycle match pulse plus a saturating match counter for status readout.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of cfg_len; must hold MAX_LEN (>= clog2(MAX_LEN+1))
CNT_W, 16, width of match_count

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
cfg_we  input  1  config load strobe
cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit 0 the last
cfg_len  input  LEN_W  pattern length, legal 1..MAX_LEN
cfg_overlap  input  1  1 = overlapping, 0 = non-overlapping
d_i  input  1  serial data bit
v_i  input  1  d_i valid
pattern_detect  output  1  one-cycle match pulse, registered
match_count  output  CNT_W  number of matches since reset/config, saturating
cfg_err  output  1  one-cycle pulse: illegal cfg_len rejected
armed  output  1  window full; comparisons active

Behaviour:
- Reset (rst=1 at edge): state IDLE, shift register 0, fill count 0, stored pattern/len/overlap 0, pattern_detect=0, match_count=0, cfg_err=0, armed=0. Reset overrides cfg_we and v_i in the same cycle.
- States: IDLE (no valid config; v_i ignored) -> FILL (collecting first len-1 valid bits) -> ARMED (every valid bit triggers a compare).
- Config: cfg_we=1 with 1<=cfg_len<=MAX_LEN latches pattern/len/overlap. It clears the shift register, fill count, match_count and pattern_detect. Next state is FILL, or ARMED directly if len=1. Illegal cfg_len (0 or >MAX_LEN): config ignored, state unchanged, cfg_err=1 for one cycle.
- cfg_we and v_i in the same cycle: config wins, data bit discarded.
- Shift: on each edge with v_i=1 (not IDLE, no cfg_we), the shift register becomes {sr[MAX_LEN-2:0], d_i}. v_i=0 cycles hold all state; only pattern_detect and cfg_err return to 0.
- FILL: fill count increments per valid bit. The bit that brings the count to len is compared in the same edge, so the first possible match is the len-th valid bit. State moves to ARMED on that bit.
- Compare: window {sr[len-2:0], d_i} vs pattern[len-1:0]. Bits at or above len are excluded.
- Match: pattern_detect=1 in the cycle after the sampling edge, for exactly one cycle. Back-to-back matches produce a continuously high pulse train. match_count increments and holds at all-ones.
- Overlap=1: stay ARMED after a match; shift register retained.
- Overlap=0: after a match, clear the shift register and fill count and go to FILL (ARMED if len=1). The next match needs len fresh valid bits.
- armed=1 only in ARMED.
- Latency: match on valid bit at edge N -> pattern_detect high during cycle N..N+1.

Optional Feature:
Macro PD_MASK_EN. When defined, adds port cfg_mask (input, MAX_LEN), latched with cfg_we. Mask bit =1 makes the corresponding pattern position don't-care in the compare. Mask reset value is all zeros. Without the macro there is no cfg_mask port and every bit within len is compared exactly.

Test Plan:
1. Load 01101, len 5, overlap=1; stream 0,1,1,0,1,1,0,1 (v_i=1 each cycle) -> pattern_detect pulses after bit 5 and bit 8; match_count=2.
2. Same load with overlap=0, same stream -> single pulse after bit 5; match_count=1; armed=0 after bit 5 until 5 new bits.
3. Repeat test 1 with v_i=0 gaps of 1-3 cycles between bits, d_i random during gaps -> identical pulses relative to valid bits; count=2.
4. Load pattern 1, len 1, overlap=1; stream 1,1,0,1 -> pattern_detect high two consecutive cycles, low, high; count=3. Then CNT_W=4 build, 20 consecutive 1s -> match_count saturates at 15.
5. cfg_we with cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err one-cycle pulse each; prior pattern still detected. cfg_we coincident with v_i -> bit not shifted.
6. Assert rst after bit 3 of a 01101 stream -> all outputs 0, state IDLE, stream ignored until a new cfg_we. With PD_MASK_EN: pattern 01101, mask 00100 -> stream 01001 matches.
